// File: rtl/bbox_tracker_multi.sv
// bbox_tracker_multi: per-colour bounding-box tracker on an Avalon-ST video stream with box/mask display and register readout
//   clk, reset                      : single clock, asynchronous active-high reset
//   sink_* / source_*               : Avalon-ST in/out, one registered stage, sink_ready = ~source_valid | source_ready
//   sink_mask[NUM_COLOURS]          : per-pixel colour-class hits
//   mode                            : 0 pass, 1 box overlay, 2 mask view (sampled at video sop)
//   s_address, s_read, s_readdata   : result readout, 1-cycle read latency
//   frame_done                      : one-cycle pulse after results are latched
module bbox_tracker_multi #(
  parameter int NUM_COLOURS = 4,
  parameter int IMAGE_W = 640,
  parameter int IMAGE_H = 480
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [23:0]            sink_data,
  input  logic [NUM_COLOURS-1:0] sink_mask,
  input  logic                   sink_valid,
  output logic                   sink_ready,
  input  logic                   sink_sop,
  input  logic                   sink_eop,
  output logic [23:0]            source_data,
  output logic                   source_valid,
  input  logic                   source_ready,
  output logic                   source_sop,
  output logic                   source_eop,
  input  logic [3:0]             mode,
  input  logic [4:0]             s_address,
  input  logic                   s_read,
  output logic [31:0]            s_readdata,
  output logic                   frame_done
);
  typedef struct packed {
    logic [10:0] min_x;
    logic [10:0] max_x;
    logic [10:0] min_y;
    logic [10:0] max_y;
  } box_t;
  localparam box_t BOX_INIT = '{min_x: 11'h7FF, max_x: 11'h0, min_y: 11'h7FF, max_y: 11'h0};
  localparam logic [11:0] X_LAST = 12'(IMAGE_W - 1);
  localparam logic [11:0] Y_END = 12'(IMAGE_H);
  logic                   src_valid_q, src_sop_q, src_eop_q, done_q;
  logic                   video_q, video_d;
  logic [23:0]            src_data_q, out_data, box_colour;
  logic [3:0]             mode_q, mode_d;
  logic [11:0]            x_q, x_d, y_q, y_d;
  logic [15:0]            frame_count_q;
  logic [31:0]            rd_q, rd_d;
  box_t                   acc_q [NUM_COLOURS];
  box_t                   acc_d [NUM_COLOURS];
  box_t                   res_q [NUM_COLOURS];
  logic [NUM_COLOURS-1:0] hit_q, hit_d, res_hit_q;
  logic                   accept, hdr_video, is_video, video_sop, pix_beat, latch, on_edge;

  function automatic logic on_box(input box_t b, input logic [11:0] x, input logic [11:0] y);
    logic in_x, in_y;
    in_x = x >= {1'b0, b.min_x} && x <= {1'b0, b.max_x};
    in_y = y >= {1'b0, b.min_y} && y <= {1'b0, b.max_y};
    return (in_x && (y == {1'b0, b.min_y} || y == {1'b0, b.max_y})) ||
           (in_y && (x == {1'b0, b.min_x} || x == {1'b0, b.max_x}));
  endfunction

  // Colour c draws in 24'hFF0000 rotated right by 8*c bits: red, green, blue, red, ...
  function automatic logic [23:0] colour(input int c);
    logic [47:0] r;
    r = {2{24'hFF0000}} >> (8 * (c % 3));
    return r[23:0];
  endfunction

  assign sink_ready   = ~src_valid_q | source_ready;
  assign accept       = sink_valid & sink_ready;
  assign hdr_video    = sink_data[3:0] == 4'h0;
  assign is_video     = sink_sop ? hdr_video : video_q;
  assign video_sop    = accept & sink_sop & hdr_video;
  assign pix_beat     = video_q & ~sink_sop;
  assign latch        = accept & sink_eop & is_video;
  assign source_data  = src_data_q;
  assign source_valid = src_valid_q;
  assign source_sop   = src_sop_q;
  assign source_eop   = src_eop_q;
  assign s_readdata   = rd_q;
  assign frame_done   = done_q;

  // x/y stop advancing once the frame is full, so surplus pixels sit at (0, IMAGE_H) and never touch a box.
  always_comb begin
    video_d = accept ? is_video & ~sink_eop : video_q;
    mode_d = video_sop ? mode : mode_q;
    x_d = x_q;
    y_d = y_q;
    acc_d = acc_q;
    hit_d = hit_q;
    if (video_sop) begin
      x_d = '0;
      y_d = '0;
      hit_d = '0;
      acc_d = '{default: BOX_INIT};
    end else if (accept && pix_beat && y_q < Y_END) begin
      x_d = x_q == X_LAST ? '0 : x_q + 12'd1;
      y_d = x_q == X_LAST ? y_q + 12'd1 : y_q;
      for (int c = 0; c < NUM_COLOURS; c++)
        if (sink_mask[c]) begin
          acc_d[c].min_x = x_q[10:0] < acc_q[c].min_x ? x_q[10:0] : acc_q[c].min_x;
          acc_d[c].max_x = x_q[10:0] > acc_q[c].max_x ? x_q[10:0] : acc_q[c].max_x;
          acc_d[c].min_y = y_q[10:0] < acc_q[c].min_y ? y_q[10:0] : acc_q[c].min_y;
          acc_d[c].max_y = y_q[10:0] > acc_q[c].max_y ? y_q[10:0] : acc_q[c].max_y;
          hit_d[c] = 1'b1;
        end
    end
  end

  // Descending scan so the lowest colour index is the last writer and wins overlaps.
  always_comb begin
    on_edge = 1'b0;
    box_colour = '0;
    for (int c = NUM_COLOURS - 1; c >= 0; c--)
      if (res_hit_q[c] && on_box(res_q[c], x_q, y_q)) begin
        on_edge = 1'b1;
        box_colour = colour(c);
      end
    out_data = pix_beat && mode_q == 4'd1 && on_edge ? box_colour :
               pix_beat && mode_q == 4'd2 ? {24{|sink_mask}} : sink_data;
  end

  always_comb begin
    rd_d = s_address == 5'd16 ? {frame_count_q, 8'h0, 8'(res_hit_q)} : 32'h0;
    for (int c = 0; c < NUM_COLOURS; c++) begin
      if (res_hit_q[c] && s_address == 5'(2 * c))
        rd_d = {5'h0, res_q[c].min_y, 5'h0, res_q[c].min_x};
      if (res_hit_q[c] && s_address == 5'(2 * c + 1))
        rd_d = {5'h0, res_q[c].max_y, 5'h0, res_q[c].max_x};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_valid_q <= 1'b0;
      src_sop_q <= 1'b0;
      src_eop_q <= 1'b0;
      src_data_q <= '0;
      done_q <= 1'b0;
      rd_q <= '0;
      video_q <= 1'b0;
      mode_q <= '0;
      x_q <= '0;
      y_q <= '0;
      acc_q <= '{default: BOX_INIT};
      hit_q <= '0;
      res_q <= '{default: '0};
      res_hit_q <= '0;
      frame_count_q <= '0;
    end else begin
      if (accept) begin
        src_valid_q <= 1'b1;
        src_data_q <= out_data;
        src_sop_q <= sink_sop;
        src_eop_q <= sink_eop;
      end else if (source_ready)
        src_valid_q <= 1'b0;
      done_q <= latch;
      if (s_read)
        rd_q <= rd_d;
      video_q <= video_d;
      mode_q <= mode_d;
      x_q <= x_d;
      y_q <= y_d;
      acc_q <= acc_d;
      hit_q <= hit_d;
      if (latch) begin
        res_q <= acc_d;
        res_hit_q <= hit_d;
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_bbox_tracker_multi.sv
// tb_bbox_tracker_multi: directed tables plus randomized packets checked against a pixel-list reference model
module tb_bbox_tracker_multi;
  localparam int NC = 4, W = 4, H = 2;
  typedef struct {logic [23:0] d; logic [NC-1:0] m; logic s; logic e; logic [23:0] exp;} beat_t;
  typedef struct {logic [4:0] a; logic [31:0] exp;} rdv_t;
  typedef struct {int c; int x; int y;} hit_t;
  logic clk = 0, reset = 0;
  logic [23:0] sink_data = 0;
  logic [NC-1:0] sink_mask = 0;
  logic sink_valid = 0, sink_sop = 0, sink_eop = 0, sink_ready;
  logic [23:0] source_data;
  logic source_valid, source_sop, source_eop, source_ready;
  logic man_rdy = 1, rand_en = 0, rand_rdy = 1;
  logic [3:0] mode = 0;
  logic [4:0] s_address = 0;
  logic s_read = 0;
  logic [31:0] s_readdata;
  logic frame_done;
  int passed = 0, total = 0, done_cnt = 0, exp_done = 0;
  logic [25:0] exp_q[$];
  logic m_video = 0;
  logic [3:0] m_mode = 0;
  int m_k = 0;
  hit_t hits[$];
  int r_minx[NC], r_maxx[NC], r_miny[NC], r_maxy[NC];
  bit [NC-1:0] r_hit = 0;
  logic [15:0] m_fc = 0;

  assign source_ready = rand_en ? rand_rdy : man_rdy;
  always #5 clk = ~clk;

  bbox_tracker_multi #(.NUM_COLOURS(NC), .IMAGE_W(W), .IMAGE_H(H)) dut (
    .clk(clk), .reset(reset),
    .sink_data(sink_data), .sink_mask(sink_mask), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop),
    .mode(mode), .s_address(s_address), .s_read(s_read), .s_readdata(s_readdata), .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  always @(posedge clk) begin
    #1;
    rand_rdy = $urandom_range(0, 3) != 0;
  end

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (!reset && source_valid && source_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL beat: unexpected source beat %h", source_data);
      end else
        check("beat", 32'({source_data, source_sop, source_eop}), 32'(exp_q.pop_front()));
    end
  end

  function automatic logic [23:0] colour(input int c);
    case (c % 3)
      0: return 24'hFF0000;
      1: return 24'h00FF00;
      default: return 24'h0000FF;
    endcase
  endfunction

  function automatic bit on_edge(input int c, input int x, input int y);
    bit ix, iy;
    ix = x >= r_minx[c] && x <= r_maxx[c];
    iy = y >= r_miny[c] && y <= r_maxy[c];
    return (ix && (y == r_miny[c] || y == r_maxy[c])) || (iy && (x == r_minx[c] || x == r_maxx[c]));
  endfunction

  function automatic logic [31:0] exp_reg(input int a);
    if (a == 16) return {m_fc, 8'h0, 4'h0, r_hit};
    if (a < 2 * NC && r_hit[a / 2])
      return a % 2 == 0 ? {5'h0, 11'(r_miny[a / 2]), 5'h0, 11'(r_minx[a / 2])}
                        : {5'h0, 11'(r_maxy[a / 2]), 5'h0, 11'(r_maxx[a / 2])};
    return 32'h0;
  endfunction

  task automatic commit();
    for (int c = 0; c < NC; c++) begin
      r_hit[c] = 0;
      foreach (hits[i])
        if (hits[i].c == c) begin
          if (!r_hit[c]) begin
            r_minx[c] = hits[i].x; r_maxx[c] = hits[i].x;
            r_miny[c] = hits[i].y; r_maxy[c] = hits[i].y;
            r_hit[c] = 1;
          end else begin
            if (hits[i].x < r_minx[c]) r_minx[c] = hits[i].x;
            if (hits[i].x > r_maxx[c]) r_maxx[c] = hits[i].x;
            if (hits[i].y < r_miny[c]) r_miny[c] = hits[i].y;
            if (hits[i].y > r_maxy[c]) r_maxy[c] = hits[i].y;
          end
        end
    end
    m_fc = m_fc + 16'd1;
    exp_done++;
  endtask

  task automatic model_beat(input logic [23:0] d, input logic [NC-1:0] m, input logic s, input logic e,
                            output logic [23:0] o);
    bit vid, found;
    int x, y;
    o = d;
    vid = s ? d[3:0] == 4'h0 : m_video;
    if (s) begin
      if (vid) begin
        m_mode = mode;
        m_k = 0;
        hits.delete();
      end
    end else if (vid) begin
      x = m_k % W;
      y = m_k / W;
      found = 0;
      if (m_k < W * H)
        for (int c = 0; c < NC; c++) if (m[c]) hits.push_back('{c, x, y});
      if (m_mode == 4'd1 && m_k < W * H) begin
        for (int c = 0; c < NC; c++)
          if (!found && r_hit[c] && on_edge(c, x, y)) begin
            o = colour(c);
            found = 1;
          end
      end else if (m_mode == 4'd2)
        o = m != 0 ? 24'hFFFFFF : 24'h000000;
      m_k++;
    end
    if (e && vid) commit();
    m_video = vid && !e;
  endtask

  task automatic model_reset();
    exp_q.delete();
    hits.delete();
    m_video = 0;
    r_hit = 0;
    m_fc = 0;
  endtask

  task automatic send_beat(input logic [23:0] d, input logic [NC-1:0] m, input logic s, input logic e,
                           input bit use_exp, input logic [23:0] exp_d);
    logic [23:0] o;
    int n = 0;
    sink_data = d; sink_mask = m; sink_sop = s; sink_eop = e; sink_valid = 1;
    @(negedge clk);
    while (!sink_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!sink_ready) begin
      total++;
      $display("FAIL accept_timeout: sink_ready stayed 0 for data %h", d);
    end else begin
      model_beat(d, m, s, e, o);
      exp_q.push_back({use_exp ? exp_d : o, s, e});
    end
    @(posedge clk); #1;
    sink_valid = 0;
  endtask

  task automatic send(input logic [23:0] d, input logic [NC-1:0] m, input logic s, input logic e);
    send_beat(d, m, s, e, 0, 24'h0);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    s_address = a; s_read = 1;
    @(posedge clk); #1;
    s_read = 0;
    @(negedge clk);
    v = s_readdata;
    @(posedge clk); #1;
  endtask

  task automatic run_reads(input rdv_t t[$], input string name);
    logic [31:0] v;
    foreach (t[i]) begin
      rd(t[i].a, v);
      check(name, v, t[i].exp);
    end
  endtask

  initial begin
    beat_t bt[$];
    rdv_t rt[$];
    logic [31:0] v;
    logic [25:0] held;
    logic [23:0] o;
    #1 reset = 1;
    @(negedge clk);
    check("rst_source_valid", 32'(source_valid), 0);
    check("rst_source_sop", 32'(source_sop), 0);
    check("rst_source_eop", 32'(source_eop), 0);
    check("rst_source_data", 32'(source_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_readdata", s_readdata, 0);
    check("rst_sink_ready", 32'(sink_ready), 1);
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1;

    // 4x2 frame, colour 0 hits at (1,0) and (3,1)
    bt.push_back('{24'h000000, 4'h0, 1, 0, 24'h000000});
    for (int i = 0; i < 8; i++)
      bt.push_back('{24'h101010 * 24'(i + 1), (i == 1 || i == 7) ? 4'h1 : 4'h0, 0, i == 7, 24'h101010 * 24'(i + 1)});
    foreach (bt[i]) send_beat(bt[i].d, bt[i].m, bt[i].s, bt[i].e, 1, bt[i].exp);
    rt = '{'{5'd0, 32'h00000001}, '{5'd1, 32'h00010003}, '{5'd16, 32'h00010001},
           '{5'd2, 32'h0}, '{5'd3, 32'h0}, '{5'd8, 32'h0}, '{5'd31, 32'h0}};
    run_reads(rt, "frame_read");

    // control packet passes bit-exact and leaves results alone
    bt.delete();
    bt.push_back('{24'h00000F, 4'hF, 1, 0, 24'h00000F});
    bt.push_back('{24'hA5A5A0, 4'hF, 0, 0, 24'hA5A5A0});
    bt.push_back('{24'h5A5A50, 4'hF, 0, 0, 24'h5A5A50});
    bt.push_back('{24'h123450, 4'hF, 0, 1, 24'h123450});
    foreach (bt[i]) send_beat(bt[i].d, bt[i].m, bt[i].s, bt[i].e, 1, bt[i].exp);
    rt = '{'{5'd16, 32'h00010001}, '{5'd0, 32'h00000001}};
    run_reads(rt, "ctrl_read");

    // box overlay of colour-0 box (1,0)-(3,1); mode changes mid-frame must not matter
    bt.delete();
    bt.push_back('{24'hABC000, 4'h0, 1, 0, 24'hABC000});
    for (int i = 0; i < 8; i++)
      bt.push_back('{24'h123456 + 24'(i), 4'h0, 0, i == 7, (i % 4 == 0) ? 24'h123456 + 24'(i) : 24'hFF0000});
    mode = 4'd1;
    send_beat(bt[0].d, bt[0].m, bt[0].s, bt[0].e, 1, bt[0].exp);
    mode = 4'd0;
    for (int i = 1; i < 9; i++) send_beat(bt[i].d, bt[i].m, bt[i].s, bt[i].e, 1, bt[i].exp);

    // back-pressure: source_ready low for 5 cycles while a beat is pending
    send(24'h000000, 4'h0, 1, 0);
    send(24'h777770, 4'h0, 0, 0);
    man_rdy = 0;
    fork
      send(24'h888880, 4'h0, 0, 0);
      begin
        @(negedge clk);
        held = {source_data, source_sop, source_eop};
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", 32'(source_valid), 1);
          check("stall_sink_ready", 32'(sink_ready), 0);
          check("stall_stable", 32'({source_data, source_sop, source_eop}), 32'(held));
        end
        @(posedge clk); #1 man_rdy = 1;
      end
    join
    for (int i = 2; i < 8; i++) send(24'h010100 * 24'(i), 4'h0, 0, i == 7);

    // partial frame discarded by a second video sop; read coinciding with the eop latch
    send(24'h000000, 4'h0, 1, 0);
    for (int i = 0; i < 3; i++) send(24'h222220, 4'h2, 0, 0);
    send(24'h000000, 4'h0, 1, 0);
    for (int i = 0; i < 7; i++) send(24'h333330, i == 6 ? 4'h4 : 4'h0, 0, 0);
    sink_data = 24'h444440; sink_mask = 4'h0; sink_sop = 0; sink_eop = 1; sink_valid = 1;
    s_address = 5'd16; s_read = 1;
    @(negedge clk);
    check("latch_sink_ready", 32'(sink_ready), 1);
    model_beat(sink_data, sink_mask, 0, 1, o);
    exp_q.push_back({o, 1'b0, 1'b1});
    @(posedge clk); #1;
    sink_valid = 0; s_read = 0;
    @(negedge clk);
    check("read_at_latch", s_readdata, 32'h00030000);
    check("frame_done_high", 32'(frame_done), 1);
    @(negedge clk);
    check("frame_done_low", 32'(frame_done), 0);
    @(posedge clk); #1;
    rt = '{'{5'd16, 32'h00040004}, '{5'd4, 32'h00010002}, '{5'd5, 32'h00010002},
           '{5'd2, 32'h0}, '{5'd0, 32'h0}};
    run_reads(rt, "restart_read");

    // reset mid-frame, then a clean frame with no hits
    send(24'h000000, 4'h0, 1, 0);
    send(24'h555550, 4'hF, 0, 0);
    send(24'h666660, 4'hF, 0, 0);
    @(negedge clk);
    @(posedge clk); #1 reset = 1;
    model_reset();
    @(negedge clk);
    check("midrst_valid", 32'(source_valid), 0);
    check("midrst_sink_ready", 32'(sink_ready), 1);
    check("midrst_readdata", s_readdata, 0);
    @(posedge clk); #1 reset = 0;
    send(24'h000000, 4'h0, 1, 0);
    for (int i = 0; i < 8; i++) send(24'h0F0F00, 4'h0, 0, i == 7);
    rt.delete();
    for (int a = 0; a < 8; a++) rt.push_back('{5'(a), 32'h0});
    rt.push_back('{5'd16, 32'h00010000});
    run_reads(rt, "postrst_read");

    // randomized packets with random back-pressure
    rand_en = 1;
    for (int p = 0; p < 40; p++) begin
      int n, a;
      bit part;
      n = $urandom_range(0, W * H + 3);
      if ($urandom_range(0, 4) == 0) begin
        send({20'($urandom), 4'($urandom_range(1, 15))}, 4'($urandom), 1, n == 0);
        for (int i = 0; i < n; i++) send(24'($urandom), 4'($urandom), 0, i == n - 1);
      end else begin
        part = $urandom_range(0, 7) == 0;
        mode = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
        send({20'($urandom), 4'h0}, 4'h0, 1, !part && n == 0);
        mode = 4'($urandom_range(0, 15));
        for (int i = 0; i < n; i++)
          send(24'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)), 0, !part && i == n - 1);
      end
      a = $urandom_range(0, 31);
      rd(5'(a), v);
      check("rand_read", v, exp_reg(a));
      rd(5'd16, v);
      check("rand_status", v, exp_reg(16));
    end
    rand_en = 0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 0);
    check("frame_done_count", 32'(done_cnt), 32'(exp_done));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
